mem_port_arbiter: RTL and testbench

- Shares the single-port synchronous memory between two requesters. Port C is the CPU fetch/data path. Port L is the program loader/debug port.
- Sits between the requesters and the Memory block. It drives memory Address, Write_EN, Mem_En and DIn, and returns DOut to whichever requester was granted.
- Uses round-robin fairness. Also provides an exclusive lock, so the loader can own memory while it downloads a program.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/acknowledge and memory-side signals of the two-port memory arbiter.
// Handshake: a requester raises Req with Wr/Addr/WData and holds all of them
// stable until it samples its Ack high for one cycle; Req still high in the
// following idle cycle is a new request.
interface mem_port_arbiter_if #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 8
);
  logic                 CPU_Req;
  logic                 CPU_Wr;
  logic [AddrWidth-1:0] CPU_Addr;
  logic [DataWidth-1:0] CPU_WData;
  logic                 CPU_Ack;
  logic                 LDR_Req;
  logic                 LDR_Wr;
  logic [AddrWidth-1:0] LDR_Addr;
  logic [DataWidth-1:0] LDR_WData;
  logic                 LDR_Ack;
  logic                 LDR_Lock;
  logic                 LDR_LockAck;
  logic [DataWidth-1:0] RData;
  logic                 MEM_En;
  logic                 MEM_Wr;
  logic [AddrWidth-1:0] MEM_Addr;
  logic [DataWidth-1:0] MEM_WData;
  logic [DataWidth-1:0] MEM_RData;
  logic                 Busy;

  modport slave (
    input  CPU_Req, CPU_Wr, CPU_Addr, CPU_WData,
    input  LDR_Req, LDR_Wr, LDR_Addr, LDR_WData, LDR_Lock,
    input  MEM_RData,
    output CPU_Ack, LDR_Ack, LDR_LockAck, RData,
    output MEM_En, MEM_Wr, MEM_Addr, MEM_WData, Busy
  );

  modport master (
    output CPU_Req, CPU_Wr, CPU_Addr, CPU_WData,
    output LDR_Req, LDR_Wr, LDR_Addr, LDR_WData, LDR_Lock,
    output MEM_RData,
    input  CPU_Ack, LDR_Ack, LDR_LockAck, RData,
    input  MEM_En, MEM_Wr, MEM_Addr, MEM_WData, Busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between the
// CPU port and the loader port, with an exclusive loader lock.
module mem_port_arbiter #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  mem_port_arbiter_if.slave    bus,
  output logic [1:0]           dbg_state
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESP   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_L = 1'b1;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 lock_q, lock_d;
  logic                 en_q, en_d;
  logic                 wr_q, wr_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 grant_c, grant_l;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      owner_q <= PORT_C;
      last_q  <= PORT_L;
      lock_q  <= 1'b0;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    lock_d  = lock_q;
    en_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    grant_c = 1'b0;
    grant_l = 1'b0;
    case (state_q)
      IDLE: begin
        // Lock wins over any pending request; on a tie the port not served last wins.
        if (bus.LDR_Lock) begin
          state_d = LOCKED;
          lock_d  = 1'b1;
        end else if (bus.CPU_Req && (!bus.LDR_Req || last_q == PORT_L)) begin
          grant_c = 1'b1;
        end else if (bus.LDR_Req) begin
          grant_l = 1'b1;
        end
      end
      LOCKED: begin
        if (!bus.LDR_Lock) begin
          state_d = IDLE;
          lock_d  = 1'b0;
        end else if (bus.LDR_Req) begin
          grant_l = 1'b1;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        last_d = owner_q;
        if (lock_q && bus.LDR_Lock) begin
          state_d = LOCKED;
        end else begin
          state_d = IDLE;
          lock_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_c) begin
      state_d = ISSUE;
      owner_d = PORT_C;
      en_d    = 1'b1;
      wr_d    = bus.CPU_Wr;
      addr_d  = bus.CPU_Addr;
      wdata_d = bus.CPU_WData;
    end else if (grant_l) begin
      state_d = ISSUE;
      owner_d = PORT_L;
      en_d    = 1'b1;
      wr_d    = bus.LDR_Wr;
      addr_d  = bus.LDR_Addr;
      wdata_d = bus.LDR_WData;
    end
  end

  assign bus.MEM_En      = en_q;
  assign bus.MEM_Wr      = wr_q;
  assign bus.MEM_Addr    = addr_q;
  assign bus.MEM_WData   = wdata_q;
  assign bus.CPU_Ack     = (state_q == RESP) && (owner_q == PORT_C);
  assign bus.LDR_Ack     = (state_q == RESP) && (owner_q == PORT_L);
  // Memory read data is already registered by the memory, so pass it straight through.
  assign bus.RData       = (state_q == RESP) ? bus.MEM_RData : '0;
  assign bus.Busy        = (state_q == ISSUE) || (state_q == RESP);
  assign bus.LDR_LockAck = lock_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// two-port traffic checked against a reference memory and round-robin model.
module tb_mem_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam logic PC = 1'b0;
  localparam logic PL = 1'b1;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] dbg_state;
  int         total = 0;
  int         bad = 0;

  mem_port_arbiter_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

  mem_port_arbiter #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- memory model ----------------
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
  endfunction

  logic [DW-1:0] mem [256];
  logic [255:0]  written = '0;
  logic [DW-1:0] mem_dout = '0;
  assign bus.MEM_RData = mem_dout;

  always @(posedge Clk) begin
    if (bus.MEM_En) begin
      if (bus.MEM_Wr) begin
        mem[bus.MEM_Addr] = bus.MEM_WData;
        written[bus.MEM_Addr] = 1'b1;
      end else begin
        mem_dout = written[bus.MEM_Addr] ? mem[bus.MEM_Addr] : init_val(bus.MEM_Addr);
      end
    end
  end

  int cpu_acks = 0;
  int ldr_acks = 0;
  always @(posedge Clk) begin
    if (bus.CPU_Ack) cpu_acks++;
    if (bus.LDR_Ack) ldr_acks++;
  end

  logic [DW-1:0] ref_mem [256];

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.CPU_Req = 1'b0; bus.CPU_Wr = 1'b0; bus.CPU_Addr = '0; bus.CPU_WData = '0;
    bus.LDR_Req = 1'b0; bus.LDR_Wr = 1'b0; bus.LDR_Addr = '0; bus.LDR_WData = '0;
    bus.LDR_Lock = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic access(input logic port, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, output logic [DW-1:0] rd, output int lat);
    @(negedge Clk);
    if (port == PC) begin
      bus.CPU_Req = 1'b1; bus.CPU_Wr = wr; bus.CPU_Addr = addr; bus.CPU_WData = data;
    end else begin
      bus.LDR_Req = 1'b1; bus.LDR_Wr = wr; bus.LDR_Addr = addr; bus.LDR_WData = data;
    end
    lat = -1;
    rd = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      if ((port == PC && bus.CPU_Ack) || (port == PL && bus.LDR_Ack)) begin
        lat = k;
        rd = bus.RData;
        break;
      end
    end
    if (port == PC) bus.CPU_Req = 1'b0;
    else bus.LDR_Req = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    total++; if ({bus.CPU_Ack, bus.LDR_Ack, bus.LDR_LockAck} !== 3'b000) begin bad++; $display("FAIL reset_acks got=%b exp=000", {bus.CPU_Ack, bus.LDR_Ack, bus.LDR_LockAck}); end
    total++; if ({bus.MEM_En, bus.MEM_Wr, bus.Busy} !== 3'b000) begin bad++; $display("FAIL reset_ctrl got=%b exp=000", {bus.MEM_En, bus.MEM_Wr, bus.Busy}); end
    total++; if ({bus.MEM_Addr, bus.MEM_WData, bus.RData} !== 24'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {bus.MEM_Addr, bus.MEM_WData, bus.RData}); end
    Reset = 1'b0;
    @(negedge Clk);
    total++; if ({bus.MEM_En, bus.Busy, bus.LDR_LockAck} !== 3'b000) begin bad++; $display("FAIL post_reset_idle got=%b exp=000", {bus.MEM_En, bus.Busy, bus.LDR_LockAck}); end
  endtask

  task automatic test_single_read();
    do_reset();
    bus.CPU_Req = 1'b1; bus.CPU_Wr = 1'b0; bus.CPU_Addr = 8'h10;
    @(negedge Clk);
    total++; if ({bus.MEM_En, bus.MEM_Wr, bus.Busy, bus.CPU_Ack} !== 4'b1010) begin bad++; $display("FAIL sr_issue got=%b exp=1010", {bus.MEM_En, bus.MEM_Wr, bus.Busy, bus.CPU_Ack}); end
    total++; if (bus.MEM_Addr !== 8'h10) begin bad++; $display("FAIL sr_addr got=%h exp=10", bus.MEM_Addr); end
    @(negedge Clk);
    total++; if ({bus.CPU_Ack, bus.LDR_Ack, bus.MEM_En} !== 3'b100) begin bad++; $display("FAIL sr_ack got=%b exp=100", {bus.CPU_Ack, bus.LDR_Ack, bus.MEM_En}); end
    total++; if (bus.RData !== ref_mem[8'h10]) begin bad++; $display("FAIL sr_rdata got=%h exp=%h", bus.RData, ref_mem[8'h10]); end
    bus.CPU_Req = 1'b0;
    @(negedge Clk);
    total++; if ({bus.CPU_Ack, bus.Busy} !== 2'b00) begin bad++; $display("FAIL sr_after got=%b exp=00", {bus.CPU_Ack, bus.Busy}); end
  endtask

  task automatic test_ldr_write_readback();
    logic [DW-1:0] rd;
    int lat, l0;
    do_reset();
    l0 = ldr_acks;
    access(PL, 1'b1, 8'h20, 8'h3C, rd, lat);
    ref_mem[8'h20] = 8'h3C;
    total++; if (lat != 2) begin bad++; $display("FAIL lw_lat got=%0d exp=2", lat); end
    access(PC, 1'b0, 8'h20, 8'h00, rd, lat);
    total++; if (rd !== 8'h3C) begin bad++; $display("FAIL lw_readback got=%h exp=3c", rd); end
    total++; if (ldr_acks - l0 != 1) begin bad++; $display("FAIL lw_ack_pulses got=%0d exp=1", ldr_acks - l0); end
  endtask

  task automatic test_contention();
    logic [DW:0] exp_q[$];
    logic [DW:0] got, exp_v;
    logic exp_last, w;
    int n;
    do_reset();
    bus.CPU_Req = 1'b1; bus.CPU_Wr = 1'b0; bus.CPU_Addr = 8'h40;
    bus.LDR_Req = 1'b1; bus.LDR_Wr = 1'b0; bus.LDR_Addr = 8'h41;
    exp_last = PL;
    for (int i = 0; i < 4; i++) begin
      w = ~exp_last;
      exp_q.push_back({w, (w == PC) ? ref_mem[8'h40] : ref_mem[8'h41]});
      exp_last = w;
    end
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      if (bus.CPU_Ack && bus.LDR_Ack) begin
        total++; bad++; $display("FAIL ct_both_ack cycle=%0d", k);
      end else if (bus.CPU_Ack || bus.LDR_Ack) begin
        got = {bus.LDR_Ack, bus.RData};
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL ct_extra_ack got=%h exp=none", got); end
        else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin bad++; $display("FAIL ct_grant got=%h exp=%h", got, exp_v); end
        end
        total++; if (k != 3 * n + 2) begin bad++; $display("FAIL ct_cycle got=%0d exp=%0d", k, 3 * n + 2); end
        n++;
      end
    end
    idle_inputs();
    total++; if (n != 4) begin bad++; $display("FAIL ct_count got=%0d exp=4", n); end
  endtask

  task automatic test_lock();
    logic [DW-1:0] rd;
    int lat, c0;
    do_reset();
    bus.CPU_Req = 1'b1; bus.CPU_Wr = 1'b0; bus.CPU_Addr = 8'h10;
    @(negedge Clk);
    bus.LDR_Lock = 1'b1;
    @(negedge Clk);
    total++; if ({bus.CPU_Ack, bus.LDR_LockAck} !== 2'b10) begin bad++; $display("FAIL lk_inflight got=%b exp=10", {bus.CPU_Ack, bus.LDR_LockAck}); end
    total++; if (bus.RData !== ref_mem[8'h10]) begin bad++; $display("FAIL lk_inflight_data got=%h exp=%h", bus.RData, ref_mem[8'h10]); end
    bus.CPU_Addr = 8'h11;
    @(negedge Clk);
    @(negedge Clk);
    total++; if ({bus.LDR_LockAck, bus.Busy} !== 2'b10) begin bad++; $display("FAIL lk_enter got=%b exp=10", {bus.LDR_LockAck, bus.Busy}); end
    c0 = cpu_acks;
    for (int i = 0; i < 3; i++) begin
      access(PL, 1'b1, 8'(i), 8'(8'h11 * (i + 1)), rd, lat);
      ref_mem[i] = 8'(8'h11 * (i + 1));
      total++; if (lat != 2 || bus.LDR_LockAck !== 1'b1) begin bad++; $display("FAIL lk_write%0d got lat=%0d lockack=%b exp lat=2 lockack=1", i, lat, bus.LDR_LockAck); end
    end
    @(negedge Clk);
    total++; if (cpu_acks != c0 || bus.LDR_LockAck !== 1'b1) begin bad++; $display("FAIL lk_cpu_stall got acks=%0d lockack=%b exp acks=%0d lockack=1", cpu_acks, bus.LDR_LockAck, c0); end
    bus.LDR_Lock = 1'b0;
    @(negedge Clk);
    total++; if (bus.LDR_LockAck !== 1'b0) begin bad++; $display("FAIL lk_release got=%b exp=0", bus.LDR_LockAck); end
    lat = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (bus.CPU_Ack) begin lat = k; rd = bus.RData; break; end
    end
    total++; if (lat != 2) begin bad++; $display("FAIL lk_cpu_resume got=%0d exp=2", lat); end
    total++; if (rd !== ref_mem[8'h11]) begin bad++; $display("FAIL lk_cpu_data got=%h exp=%h", rd, ref_mem[8'h11]); end
    bus.CPU_Req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      access(PC, 1'b0, 8'(i), 8'h00, rd, lat);
      total++; if (rd !== 8'(8'h11 * (i + 1))) begin bad++; $display("FAIL lk_readback%0d got=%h exp=%h", i, rd, 8'(8'h11 * (i + 1))); end
    end
  endtask

  task automatic test_reset_in_issue();
    logic [DW-1:0] rd;
    int lat, c0;
    do_reset();
    bus.CPU_Req = 1'b1; bus.CPU_Wr = 1'b1; bus.CPU_Addr = 8'h05; bus.CPU_WData = 8'h77;
    @(negedge Clk);
    total++; if ({bus.MEM_En, bus.MEM_Wr, bus.Busy} !== 3'b111) begin bad++; $display("FAIL ri_issue got=%b exp=111", {bus.MEM_En, bus.MEM_Wr, bus.Busy}); end
    c0 = cpu_acks;
    Reset = 1'b1;
    bus.CPU_Req = 1'b0;
    @(negedge Clk);
    total++; if ({bus.MEM_En, bus.Busy, bus.CPU_Ack} !== 3'b000) begin bad++; $display("FAIL ri_after got=%b exp=000", {bus.MEM_En, bus.Busy, bus.CPU_Ack}); end
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    total++; if (cpu_acks != c0) begin bad++; $display("FAIL ri_no_ack got=%0d exp=%0d", cpu_acks, c0); end
    ref_mem[8'h05] = 8'h77;
    access(PC, 1'b0, 8'h05, 8'h00, rd, lat);
    total++; if (rd !== 8'h77) begin bad++; $display("FAIL ri_mem got=%h exp=77", rd); end
  endtask

  task automatic test_back_to_back();
    int l1, l2;
    do_reset();
    bus.CPU_Req = 1'b1; bus.CPU_Wr = 1'b0; bus.CPU_Addr = 8'h30;
    l1 = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (bus.CPU_Ack) begin l1 = k; break; end
    end
    total++; if (l1 != 2 || bus.RData !== ref_mem[8'h30]) begin bad++; $display("FAIL bb_first got lat=%0d data=%h exp lat=2 data=%h", l1, bus.RData, ref_mem[8'h30]); end
    bus.CPU_Addr = 8'h31;
    l2 = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (bus.CPU_Ack) begin l2 = k; break; end
    end
    total++; if (l2 != 3 || bus.RData !== ref_mem[8'h31]) begin bad++; $display("FAIL bb_second got lat=%0d data=%h exp lat=3 data=%h", l2, bus.RData, ref_mem[8'h31]); end
    bus.CPU_Req = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] who;
    logic wr [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] dt [2];
    logic last, first, port, both;
    int lat;
    do_reset();
    last = PL;
    for (int it = 0; it < 40; it++) begin
      @(negedge Clk);
      who = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        wr[p] = 1'($urandom_range(0, 1));
        ad[p] = 8'($urandom_range(0, 255));
        dt[p] = 8'($urandom_range(0, 255));
      end
      bus.CPU_Req = who[0]; bus.CPU_Wr = wr[0]; bus.CPU_Addr = ad[0]; bus.CPU_WData = dt[0];
      bus.LDR_Req = who[1]; bus.LDR_Wr = wr[1]; bus.LDR_Addr = ad[1]; bus.LDR_WData = dt[1];
      both = (who == 2'b11);
      first = both ? ~last : who[1];
      for (int n = 0; n < (both ? 2 : 1); n++) begin
        port = (n == 0) ? first : ~first;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
          @(negedge Clk);
          if (bus.CPU_Ack || bus.LDR_Ack) begin lat = k; break; end
        end
        total++; if (lat != ((n == 0) ? 2 : 3)) begin bad++; $display("FAIL rnd_lat it=%0d got=%0d exp=%0d", it, lat, (n == 0) ? 2 : 3); end
        if (lat > 0) begin
          total++; if ({bus.CPU_Ack, bus.LDR_Ack} !== ((port == PC) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rnd_grant it=%0d got=%b exp_port=%0d", it, {bus.CPU_Ack, bus.LDR_Ack}, port); end
          if (!wr[port]) begin
            total++; if (bus.RData !== ref_mem[ad[port]]) begin bad++; $display("FAIL rnd_data it=%0d got=%h exp=%h", it, bus.RData, ref_mem[ad[port]]); end
          end else begin
            ref_mem[ad[port]] = dt[port];
          end
        end
        last = port;
        if (port == PC) bus.CPU_Req = 1'b0;
        else bus.LDR_Req = 1'b0;
        if (lat < 0) begin
          do_reset();
          last = PL;
          break;
        end
      end
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    test_reset();
    test_single_read();
    test_ldr_write_readback();
    test_contention();
    test_lock();
    test_reset_in_issue();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
